oled_field_seq: RTL and testbench
=================================

OLED_FIELD_SEQ -- requirements
Module: oled_field_seq

Interface
REQ-001 SHALL have parameter NUM_FIELDS, default 4, number of display fields; field i maps to OLED row i.
REQ-002 SHALL have parameter CHARS_PER_FIELD, default 8, characters per field; char j maps to column j.
REQ-003 SHALL have parameter TIMEOUT, default 1023, maximum cycles to wait for char_done.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port upd_req  input  NUM_FIELDS  per-field update request pulse.
REQ-007 SHALL have port clr_all  input  1  full-screen clear request pulse.
REQ-008 SHALL have port field_chars  input  NUM_FIELDS*CHARS_PER_FIELD*8  ASCII per field; field i char j at bits [(i*CPF+j)*8 +: 8].
REQ-009 SHALL have port char_done  input  1  OLED driver single-cycle write-complete pulse.
REQ-010 SHALL have port char_wr  output  1  single-cycle character write strobe.
REQ-011 SHALL have port char_code  output  8  ASCII code, valid while char_wr=1.
REQ-012 SHALL have port char_row  output  ROW_W=max(1,clog2(NUM_FIELDS))  target row.
REQ-013 SHALL have port char_col  output  COL_W=max(1,clog2(CHARS_PER_FIELD))  target column.
REQ-014 SHALL have port field_ld  output  NUM_FIELDS  one-hot pulse marking field snapshot.
REQ-015 SHALL have port clr_reg  output  1  high for the whole CLEAR state.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port err  output  1  single-cycle pulse on char_done timeout.

Function
REQ-018 SHALL keep pending[NUM_FIELDS] and clr_pend bits; an upd_req[i] or clr_all pulse SHALL set the bit on the next edge, in any state.
REQ-019 SHALL implement states IDLE, CLEAR, LOAD, WRITE, WAIT.
REQ-020 IDLE: clr_pend=1 -> CLEAR, with clr_pend and all pending bits cleared; else any pending -> LOAD, with the selected bit cleared; else stay.
REQ-021 LOAD: SHALL pulse field_ld[sel] for one cycle, snapshot field sel's CHARS_PER_FIELD bytes, reset char index to 0, and go to WRITE.
REQ-022 CLEAR: SHALL write ASCII 0x20 to every row/column, row-major from (0,0), using the same WRITE/WAIT handshake.
REQ-023 WRITE: SHALL assert char_wr for exactly one cycle with code/row/col stable, then go to WAIT.
REQ-024 WAIT: on char_done, if the last position is written -> IDLE, else increment the index -> WRITE. Minimum rate is one char per 2 cycles.
REQ-025 char_done outside WAIT SHALL be ignored.
REQ-026 upd_req[sel] arriving during that field's write SHALL re-set pending and cause a full rewrite afterwards; the in-flight write SHALL use the old snapshot.
REQ-027 clr_all during a field write SHALL NOT abort it; CLEAR SHALL follow in the next IDLE.
REQ-028 The WAIT cycle counter SHALL reach TIMEOUT without char_done -> pulse err, abandon the sequence, go to IDLE; pending bits are unaffected.
REQ-029 Outputs SHALL be registered (Moore); char_code/row/col SHALL be 0 outside WRITE.

Reset
REQ-030 rst=0 SHALL force IDLE, clear pending, set clr_pend=1, and zero all outputs, including mid-sequence.
REQ-031 The first action after reset release SHALL be a full CLEAR.

Configuration
REQ-032 With OLED_RR_ARB_EN defined, field selection SHALL be round-robin, starting at the index after the last served field.
REQ-033 Without OLED_RR_ARB_EN, the lowest pending index SHALL always win.

Structure
REQ-034 A shared package oled_pkg SHALL hold the state enum, the ASCII_SPACE constant, and the ROW_W/COL_W width functions.
REQ-035 Arbitration SHALL be a sub-module oled_field_arb (pending vector in, one-hot grant out, macro-selected policy).

Verification
REQ-036 Release reset with char_done echoed 1 cycle after char_wr -> exactly 32 writes of 0x20 covering rows 0-3 and cols 0-7, clr_reg high throughout, then busy=0.
REQ-037 upd_req=4'b0100 with field 2 "COINS025" -> field_ld=4'b0100 for 1 cycle, then 8 writes on row 2 with cols 0-7 and codes 0x43,0x4F,...,0x35.
REQ-038 upd_req=4'b1010 in one cycle -> field 1 written before field 3 (both builds from reset).
REQ-039 Hold char_done low after char_wr -> err pulses exactly 1023 cycles into WAIT, FSM in IDLE next cycle.
REQ-040 rst low during the 4th char of a field write -> outputs 0 immediately; after release, a 32-char clear occurs and no field write follows.

Source files
------------

// File: rtl/oled_pkg.sv
// oled_pkg: shared types and helpers for the OLED field sequencer.
package oled_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // Legacy state encodings, kept as named constants for existing users
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        CLEAR = ST_CLEAR,
        LOAD  = ST_LOAD,
        WRITE = ST_WRITE,
        WAIT  = ST_WAIT
    } state_t;

    // Row address width: one row per field, never narrower than 1 bit
    function automatic int unsigned row_w(input int unsigned num_fields);
        return (num_fields > 1) ? $clog2(num_fields) : 1;
    endfunction

    // Column address width: one column per character, never narrower than 1 bit
    function automatic int unsigned col_w(input int unsigned chars_per_field);
        return (chars_per_field > 1) ? $clog2(chars_per_field) : 1;
    endfunction

endpackage

// File: rtl/oled_field_arb.sv
// oled_field_arb: picks one pending field and returns a one-hot grant.
// Build macro OLED_RR_ARB_EN selects round-robin (search starts after last_idx);
// without it the lowest pending index always wins.
module oled_field_arb
    import oled_pkg::*;
#(
    parameter  int unsigned NUM_FIELDS = 4,
    localparam int unsigned IDX_W      = row_w(NUM_FIELDS)
) (
    input  logic [NUM_FIELDS-1:0] pending,
    input  logic [IDX_W-1:0]      last_idx,
    output logic [NUM_FIELDS-1:0] grant
);

`ifdef OLED_RR_ARB_EN
    logic found;

    // Round-robin search: walk the fields cyclically starting after last_idx
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_FIELDS; k++) begin
            for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
                if (!found && pending[f] && (f == (32'(last_idx) + k) % NUM_FIELDS)) begin
                    grant[f] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end
`else
    logic found;
    logic unused_last;

    assign unused_last = ^last_idx;

    // Fixed priority: the lowest pending index wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
            if (!found && pending[f]) begin
                grant[f] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/oled_field_seq.sv
// oled_field_seq: turns per-field update / full-clear requests into a stream of
// single-character writes (char_wr / char_done handshake) to an OLED text driver.
// Build macro OLED_RR_ARB_EN (in oled_field_arb) enables round-robin field selection.
module oled_field_seq
    import oled_pkg::*;
#(
    parameter  int unsigned NUM_FIELDS      = 4,
    parameter  int unsigned CHARS_PER_FIELD = 8,
    parameter  int unsigned TIMEOUT         = 1023,
    localparam int unsigned ROW_W           = row_w(NUM_FIELDS),
    localparam int unsigned COL_W           = col_w(CHARS_PER_FIELD)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_FIELDS-1:0]                   upd_req,
    input  logic                                    clr_all,
    input  logic [NUM_FIELDS*CHARS_PER_FIELD*8-1:0] field_chars,
    input  logic                                    char_done,
    output logic                                    char_wr,
    output logic [7:0]                              char_code,
    output logic [ROW_W-1:0]                        char_row,
    output logic [COL_W-1:0]                        char_col,
    output logic [NUM_FIELDS-1:0]                   field_ld,
    output logic                                    clr_reg,
    output logic                                    busy,
    output logic                                    err
);

    localparam int unsigned    CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_FIELDS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(CHARS_PER_FIELD - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [NUM_FIELDS-1:0]   pend_q, pend_clr;
    logic                    clr_pend_q, clr_pend_clr;
    logic                    clr_mode_q, clr_mode_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [CNT_W-1:0]        wcnt_q, wcnt_d;
    logic [ROW_W-1:0]        last_q;
    logic                    err_d;
    logic                    take;
    logic [NUM_FIELDS-1:0]   grant;
    logic [ROW_W-1:0]        gidx;
    logic [7:0]              snap_q [CHARS_PER_FIELD];

    oled_field_arb #(
        .NUM_FIELDS (NUM_FIELDS)
    ) u_arb (
        .pending  (pend_q),
        .last_idx (last_q),
        .grant    (grant)
    );

    // One-hot grant to field index
    always_comb begin
        gidx = '0;
        for (int unsigned k = 0; k < NUM_FIELDS; k++) begin
            if (grant[k]) gidx = ROW_W'(k);
        end
    end

    // Next-state logic; in field mode row holds the field index, in clear mode it walks all rows
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        clr_mode_d   = clr_mode_q;
        wcnt_d       = wcnt_q;
        err_d        = 1'b0;
        pend_clr     = '0;
        clr_pend_clr = 1'b0;
        take         = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_pend_q) begin
                    state_d      = CLEAR;
                    clr_pend_clr = 1'b1;
                    pend_clr     = '1;
                    clr_mode_d   = 1'b1;
                end else if (|pend_q) begin
                    state_d  = LOAD;
                    pend_clr = grant;
                    row_d    = gidx;
                    take     = 1'b1;
                end
            end
            CLEAR: begin
                row_d   = '0;
                col_d   = '0;
                state_d = WRITE;
            end
            LOAD: begin
                col_d   = '0;
                state_d = WRITE;
            end
            WRITE: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (char_done) begin
                    if (col_q == COL_LAST && (!clr_mode_q || row_q == ROW_LAST)) begin
                        state_d    = IDLE;
                        clr_mode_d = 1'b0;
                    end else begin
                        state_d = WRITE;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end else if (wcnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    clr_mode_d = 1'b0;
                    err_d      = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request bookkeeping and registered outputs.
    // Outputs are loaded from next-state values so each lines up with the state it describes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            clr_pend_q <= 1'b1;
            clr_mode_q <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            wcnt_q     <= '0;
            last_q     <= ROW_LAST;
            char_wr    <= 1'b0;
            char_code  <= '0;
            char_row   <= '0;
            char_col   <= '0;
            field_ld   <= '0;
            clr_reg    <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= (pend_q & ~pend_clr) | upd_req;
            clr_pend_q <= (clr_pend_q & ~clr_pend_clr) | clr_all;
            clr_mode_q <= clr_mode_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wcnt_q     <= wcnt_d;
            if (take) last_q <= gidx;
            char_wr    <= (state_d == WRITE);
            char_code  <= (state_d == WRITE) ? (clr_mode_d ? ASCII_SPACE : snap_q[col_d]) : '0;
            char_row   <= (state_d == WRITE) ? row_d : '0;
            char_col   <= (state_d == WRITE) ? col_d : '0;
            field_ld   <= take ? grant : '0;
            clr_reg    <= clr_mode_d;
            busy       <= (state_d != IDLE);
            err        <= err_d;
        end
    end

    // Snapshot of the granted field, captured on entry to LOAD
    always_ff @(posedge clk) begin
        if (take) begin
            for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
                if (gidx == ROW_W'(f)) begin
                    for (int unsigned j = 0; j < CHARS_PER_FIELD; j++) begin
                        snap_q[j] <= field_chars[(f*CHARS_PER_FIELD + j)*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_oled_field_seq.sv
// tb_oled_field_seq: self-checking bench for oled_field_seq.
// Expected write streams come from a request-level model (clear = 32 spaces
// row-major, field update = 8 chars of that row from the text at request time).
module tb_oled_field_seq;

    localparam int NF  = 4;
    localparam int CPF = 8;
    localparam int TO  = 1023;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NF-1:0]         upd_req;
    logic                  clr_all;
    logic [NF*CPF*8-1:0]   field_chars;
    logic                  char_done;
    logic                  char_wr;
    logic [7:0]            char_code;
    logic [1:0]            char_row;
    logic [2:0]            char_col;
    logic [NF-1:0]         field_ld;
    logic                  clr_reg;
    logic                  busy;
    logic                  err;

    oled_field_seq #(
        .NUM_FIELDS      (NF),
        .CHARS_PER_FIELD (CPF),
        .TIMEOUT         (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .upd_req     (upd_req),
        .clr_all     (clr_all),
        .field_chars (field_chars),
        .char_done   (char_done),
        .char_wr     (char_wr),
        .char_code   (char_code),
        .char_row    (char_row),
        .char_col    (char_col),
        .field_ld    (field_ld),
        .clr_reg     (clr_reg),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       clr;
        logic [1:0] row;
        logic [2:0] col;
        logic [7:0] code;
    } wr_t;

    typedef struct {
        logic [NF-1:0] upd;
        bit            clr;
        int            n_wr;
        int            n_ld;
    } vec_t;

    wr_t  got_q[$];
    wr_t  exp_q[$];
    int   got_cyc[$];
    int   ld_got[$];
    int   ld_exp[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [7:0] txt [NF][CPF];
    bit   auto_done;
    bit   force_done;
    int   lat;
    int   done_cnt;
    int   err_cnt;
    int   busy_noclr;
    int   model_last;
    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait budget expired", name);
    endtask

    task automatic set_chars();
        for (int f = 0; f < NF; f++)
            for (int c = 0; c < CPF; c++)
                field_chars[(f*CPF + c)*8 +: 8] = txt[f][c];
    endtask

    task automatic rand_text();
        for (int f = 0; f < NF; f++)
            for (int c = 0; c < CPF; c++)
                txt[f][c] = 8'($urandom_range(33, 126));
        set_chars();
    endtask

    // One clock: sample outputs #1 after the edge, record writes, run the char_done responder
    task automatic step();
        wr_t w;
        @(posedge clk);
        #1;
        cyc++;
        char_done = force_done;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) char_done = 1'b1;
        end
        if (char_wr) begin
            w.clr  = clr_reg;
            w.row  = char_row;
            w.col  = char_col;
            w.code = char_code;
            got_q.push_back(w);
            got_cyc.push_back(cyc);
            if (auto_done) done_cnt = lat;
        end else begin
            check("zero_outside_write", {19'd0, char_code, char_row, char_col}, 32'd0);
        end
        if (field_ld != '0) begin
            check("field_ld_onehot", 32'($onehot(field_ld)), 32'd1);
            for (int i = 0; i < NF; i++) if (field_ld[i]) ld_got.push_back(i);
        end
        if (err) err_cnt++;
        if (busy && !clr_reg) busy_noclr++;
    endtask

    task automatic clear_logs();
        got_q.delete();
        exp_q.delete();
        got_cyc.delete();
        ld_got.delete();
        ld_exp.delete();
        busy_noclr = 0;
    endtask

    // Reference model: request-level expectations
    task automatic exp_clear();
        wr_t w;
        for (int r = 0; r < NF; r++)
            for (int c = 0; c < CPF; c++) begin
                w.clr  = 1'b1;
                w.row  = 2'(r);
                w.col  = 3'(c);
                w.code = 8'h20;
                exp_q.push_back(w);
            end
    endtask

    task automatic exp_field(input int f);
        wr_t w;
        ld_exp.push_back(f);
        for (int c = 0; c < CPF; c++) begin
            w.clr  = 1'b0;
            w.row  = 2'(f);
            w.col  = 3'(c);
            w.code = txt[f][c];
            exp_q.push_back(w);
        end
        model_last = f;
    endtask

    task automatic exp_request(input logic [NF-1:0] mask, input bit clr);
        int start;
        if (clr) begin
            exp_clear();
        end else begin
            start = model_last;
`ifdef OLED_RR_ARB_EN
            for (int k = 1; k <= NF; k++)
                if (mask[(start + k) % NF]) exp_field((start + k) % NF);
`else
            for (int f = 0; f < NF; f++)
                if (mask[f]) exp_field(f);
`endif
        end
    endtask

    task automatic start_pulse(input logic [NF-1:0] m, input logic c);
        upd_req = m;
        clr_all = c;
        step();
        upd_req = '0;
        clr_all = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int  n = 0;
        int  idle_run = 0;
        bit  seen = 0;
        bit  done = 0;
        while (n < budget && !done) begin
            step();
            n++;
            if (busy) begin
                seen = 1;
                idle_run = 0;
            end else begin
                idle_run++;
                if (seen && idle_run >= 4) done = 1;
            end
        end
        if (!done) fail_bound({name, ".idle"});
    endtask

    task automatic wait_writes(input int cnt, input int budget, input string name);
        int n = 0;
        while (n < budget && got_q.size() < cnt) begin
            step();
            n++;
        end
        if (got_q.size() < cnt) fail_bound({name, ".writes"});
    endtask

    task automatic compare_all(input string name);
        check($sformatf("%s.count", name), 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s.w%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        check($sformatf("%s.ld_count", name), 32'(ld_got.size()), 32'(ld_exp.size()));
        for (int i = 0; i < ld_exp.size() && i < ld_got.size(); i++)
            check($sformatf("%s.ld%0d", name, i), 32'(ld_got[i]), 32'(ld_exp[i]));
        clear_logs();
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, ".char_wr"},   32'(char_wr),   32'd0);
        check({name, ".char_code"}, 32'(char_code), 32'd0);
        check({name, ".char_row"},  32'(char_row),  32'd0);
        check({name, ".char_col"},  32'(char_col),  32'd0);
        check({name, ".field_ld"},  32'(field_ld),  32'd0);
        check({name, ".clr_reg"},   32'(clr_reg),   32'd0);
        check({name, ".busy"},      32'(busy),      32'd0);
        check({name, ".err"},       32'(err),       32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        int    bad;
        int    w_cyc;
        int    e_cyc;
        int    n;

        tbl[0] = '{4'b0001, 1'b0,  8, 1};
        tbl[1] = '{4'b1000, 1'b0,  8, 1};
        tbl[2] = '{4'b0110, 1'b0, 16, 2};
        tbl[3] = '{4'b1111, 1'b0, 32, 4};
        tbl[4] = '{4'b0000, 1'b1, 32, 0};
        tbl[5] = '{4'b1011, 1'b1, 32, 0};
        tbl[6] = '{4'b0101, 1'b0, 16, 2};

        rst        = 1'b0;
        upd_req    = '0;
        clr_all    = 1'b0;
        char_done  = 1'b0;
        auto_done  = 1;
        force_done = 0;
        lat        = 1;
        done_cnt   = 0;
        err_cnt    = 0;
        model_last = NF - 1;
        rand_text();
        clear_logs();

        // Reset state
        repeat (3) step();
        check_outputs_zero("reset");

        // First action after reset release is a full clear at 2 cycles per char
        exp_clear();
        rst = 1'b1;
        wait_idle(300, "clear");
        check("clear.busy_without_clr_reg", 32'(busy_noclr), 32'd0);
        bad = 0;
        for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] - got_cyc[i-1] != 2) bad++;
        check("clear.write_spacing", 32'(bad), 32'd0);
        compare_all("clear");
        check("clear.busy_after", 32'(busy), 32'd0);

        // Two simultaneous requests from reset: field 1 before field 3 in either policy
        exp_request(4'b1010, 1'b0);
        start_pulse(4'b1010, 1'b0);
        wait_idle(300, "pair");
        compare_all("pair");

        // Field 2 = "COINS025"
        s = "COINS025";
        for (int j = 0; j < CPF; j++) txt[2][j] = s[j];
        set_chars();
        exp_request(4'b0100, 1'b0);
        start_pulse(4'b0100, 1'b0);
        wait_idle(300, "coins");
        if (got_q.size() >= 8) begin
            check("coins.first_code", 32'(got_q[0].code), 32'h43);
            check("coins.last_code",  32'(got_q[7].code), 32'h35);
        end
        compare_all("coins");

        // Table-driven request patterns
        for (int t = 0; t < 7; t++) begin
            rand_text();
            exp_request(tbl[t].upd, tbl[t].clr);
            start_pulse(tbl[t].upd, tbl[t].clr);
            wait_idle(600, $sformatf("tbl%0d", t));
            check($sformatf("tbl%0d.n_wr", t), 32'(got_q.size()), 32'(tbl[t].n_wr));
            check($sformatf("tbl%0d.n_ld", t), 32'(ld_got.size()), 32'(tbl[t].n_ld));
            compare_all($sformatf("tbl%0d", t));
        end

        // Re-request of the field being written: old snapshot finishes, then full rewrite
        rand_text();
        exp_field(0);
        start_pulse(4'b0001, 1'b0);
        wait_writes(3, 100, "rereq");
        for (int j = 0; j < CPF; j++) txt[0][j] = 8'($urandom_range(33, 126));
        set_chars();
        exp_field(0);
        start_pulse(4'b0001, 1'b0);
        wait_idle(300, "rereq");
        compare_all("rereq");

        // Clear request during a field write does not abort it
        rand_text();
        exp_field(1);
        start_pulse(4'b0010, 1'b0);
        wait_writes(3, 100, "clr_mid");
        exp_clear();
        start_pulse(4'b0000, 1'b1);
        wait_idle(400, "clr_mid");
        compare_all("clr_mid");

        // char_done while idle is ignored
        err_cnt    = 0;
        force_done = 1;
        repeat (6) step();
        force_done = 0;
        step();
        check("spurious_done.busy",   32'(busy), 32'd0);
        check("spurious_done.writes", 32'(got_q.size()), 32'd0);
        check("spurious_done.err",    32'(err_cnt), 32'd0);
        clear_logs();

        // Timeout: no char_done after the first write
        auto_done = 0;
        err_cnt   = 0;
        model_last = 2;
        start_pulse(4'b0100, 1'b0);
        wait_writes(1, 20, "timeout");
        w_cyc = (got_cyc.size() > 0) ? got_cyc[0] : cyc;
        n = 0;
        while (n < 1100 && !err) begin
            step();
            n++;
        end
        if (!err) fail_bound("timeout.err");
        e_cyc = cyc;
        check("timeout.latency", 32'(e_cyc - w_cyc), 32'd1024);
        check("timeout.busy_at_err", 32'(busy), 32'd0);
        step();
        check("timeout.err_single", 32'(err), 32'd0);
        check("timeout.busy_after", 32'(busy), 32'd0);
        repeat (5) step();
        check("timeout.writes", 32'(got_q.size()), 32'd1);
        check("timeout.err_count", 32'(err_cnt), 32'd1);
        clear_logs();
        auto_done = 1;

        // Randomized requests with random char_done latency
        for (int it = 0; it < 30; it++) begin
            logic [NF-1:0] m;
            bit            c;
            m   = NF'($urandom_range(1, 15));
            c   = ($urandom_range(0, 4) == 0);
            lat = $urandom_range(1, 4);
            rand_text();
            exp_request(m, c);
            start_pulse(m, c);
            wait_idle(1500, $sformatf("rnd%0d", it));
            compare_all($sformatf("rnd%0d", it));
        end
        lat = 1;

        // Asynchronous reset during the 4th character of a field write
        rand_text();
        start_pulse(4'b0001, 1'b0);
        wait_writes(4, 100, "rst_mid");
        #2;
        rst = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        done_cnt = 0;
        repeat (2) step();
        clear_logs();
        model_last = NF - 1;
        exp_clear();
        rst = 1'b1;
        wait_idle(300, "rst_mid");
        compare_all("rst_mid");
        repeat (20) step();
        check("rst_mid.no_field_write", 32'(got_q.size()), 32'd0);
        check("rst_mid.busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
